// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among 4 requesters; grant held for a whole transaction.
// Optional BUSY watchdog that aborts a stalled transaction: define ARB_WATCHDOG_EN.
module mem_port_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             mem_ready,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       sel,
    output logic             mem_req,
    output logic [N_REQ-1:0] ack,
    output logic             busy,
    output logic             err
);

    if (N_REQ != 4) begin : g_bad_n_req
        $error("mem_port_arbiter: N_REQ must be 4 to match the 2-bit mux select");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT must be in 1..255");
    end

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             win_vld;
    logic             timeout;

    // Descending scan so the candidate closest to ptr is the last (winning) assignment.
    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d   = cnt_q;
        timeout = (state_q == BUSY) && !mem_ready && (cnt_q == 8'(TIMEOUT - 1));
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (!mem_ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d      = BUSY;
                    sel_d        = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                end
            end
            BUSY: begin
                // Completion wins over a coincident watchdog expiry.
                if (mem_ready || timeout) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = sel_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign grant   = grant_q;
    assign sel     = sel_q;
    assign busy    = (state_q == BUSY);
    assign mem_req = (state_q == BUSY);
    assign ack     = (state_q == BUSY && mem_ready) ? grant_q : '0;
    assign err     = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each cycle's outputs.
// Directed arbitration scenarios followed by randomized req/mem_ready/reset traffic.
module tb_mem_port_arbiter;

    localparam int TO = 4;
`ifdef ARB_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       mem_ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       mem_req;
    logic [3:0] ack;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N_REQ(4), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mem_ready (mem_ready),
        .grant     (grant),
        .sel       (sel),
        .mem_req   (mem_req),
        .ack       (ack),
        .busy      (busy),
        .err       (err)
    );

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] sel;
        logic       mem_req;
        logic       busy;
        logic [3:0] ack;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: owner = index holding the port, -1 when the port is free.
    int owner    = -1;
    int ptr      = 0;
    int last_sel = 0;
    int cnt      = 0;

    task automatic step(input logic r, input logic [3:0] rq, input logic mr);
        exp_t e;
        int   pick;
        @(posedge clk);
        #1;
        reset     = r;
        req       = rq;
        mem_ready = mr;
        e.busy    = (owner >= 0);
        e.mem_req = (owner >= 0);
        e.grant   = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
        e.sel     = 2'(last_sel);
        e.err     = WD && (owner >= 0) && !mr && (cnt == TO - 1);
        e.ack     = ((owner >= 0) && mr) ? e.grant : 4'b0000;
        exp_q.push_back(e);
        if (r) begin
            owner = -1; ptr = 0; last_sel = 0; cnt = 0;
        end else if (owner < 0) begin
            pick = -1;
            for (int k = 0; k < 4; k++) begin
                if (pick < 0 && rq[(ptr + k) % 4]) pick = (ptr + k) % 4;
            end
            if (pick >= 0) begin
                owner = pick; last_sel = pick; cnt = 0;
            end
        end else if (mr || e.err) begin
            ptr   = (owner + 1) % 4;
            owner = -1;
        end else begin
            cnt++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e           = exp_q.pop_front();
                got.grant   = grant;
                got.sel     = sel;
                got.mem_req = mem_req;
                got.busy    = busy;
                got.ack     = ack;
                got.err     = err;
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL outputs vec %0d: got grant=%b sel=%0d mem_req=%b busy=%b ack=%b err=%b, expected grant=%b sel=%0d mem_req=%b busy=%b ack=%b err=%b",
                             vectors, got.grant, got.sel, got.mem_req, got.busy, got.ack, got.err,
                             e.grant, e.sel, e.mem_req, e.busy, e.ack, e.err);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset     = 1'b1;
        req       = 4'b0000;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (grant !== 4'b0000 || sel !== 2'd0 || mem_req !== 1'b0 || busy !== 1'b0 ||
            ack !== 4'b0000 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset state: grant=%b sel=%0d mem_req=%b busy=%b ack=%b err=%b",
                     grant, sel, mem_req, busy, ack, err);
        end
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b1);

        // Single request from requester 2, memory completes in the third BUSY cycle.
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // mem_ready while idle is ignored.
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // All requesting with an always-ready memory: rotation every two cycles.
        for (int i = 0; i < 12; i++) step(1'b0, 4'b1111, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Serve requester 1, then 1010 pending: 3 before 1.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 4'b1010, (i % 2) == 1);
        step(1'b0, 4'b0000, 1'b0);

        // Reset mid-transaction drops it; pointer restarts at 0.
        step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b0);
        step(1'b1, 4'b0010, 1'b1);
        step(1'b0, 4'b1001, 1'b0);
        step(1'b0, 4'b1001, 1'b1);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        // Long stall: transaction held (or watchdog-aborted when enabled).
        for (int i = 0; i < 310; i++) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 3) == 0);
        end
        step(1'b0, 4'b0000, 1'b0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL wait expired: %0d expected vectors never checked", exp_q.size());
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
